uart_tx_core: RTL and testbench
===============================

// Module: uart_tx_core
// PURPOSE
//  Serial UART transmitter, directly downstream of the 32-entry byte memory.
//  Requests one byte per frame with a single-cycle ready pulse and captures the memory's registered data one cycle later.
//  Shifts the byte out as 8N1, or 8E1 when parity is enabled, on tx.
//  Sits between the byte memory and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//  PARITY_EN     0    1 = insert even-parity bit after data bit 7
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk     in   1  single system clock; all state updates on posedge
//  rst     in   1  asynchronous, active-high reset
//  tx_en   in   1  level; while high, frames are requested back-to-back
//  data    in   8  byte from memory; valid the cycle after ready
//  ready   out  1  one-cycle request pulse to memory
//  tx      out  1  serial line, idle high
//  busy    out  1  high from REQ through the last stop bit
//  done    out  1  one-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//  Reset values (asynchronous): tx=1, ready=0, busy=0, done=0, state=IDLE.
//  Reset also clears baud_cnt, bit_idx, shift_reg and parity.
//  States: IDLE -> REQ -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE or REQ.
//  IDLE: tx=1, busy=0. If tx_en=1 at a posedge, go to REQ.
//  REQ: exactly one cycle with ready=1. The memory registers data on that edge.
//  LOAD: one cycle. Capture data into shift_reg at the end of the cycle and compute even parity (XOR of data bits).
//  START: tx=0 for CLKS_PER_BIT cycles.
//  DATA: bits 0..7 LSB first, each held CLKS_PER_BIT cycles.
//  PARITY: present only when PARITY_EN=1. tx = parity, held CLKS_PER_BIT cycles.
//  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. done pulses in the final cycle.
//   - After STOP, go to REQ if tx_en=1, else to IDLE.
//   - This gives back-to-back frames with no extra idle cycle.
//  tx is driven from a register and changes only on state or bit boundaries.
//  Latency: tx_en rising -> start bit begins 3 edges later (IDLE->REQ->LOAD->START).
//  Frame period while streaming = 2 + (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//  baud_cnt counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on entry to START.
//   - Width: $clog2(CLKS_PER_BIT).
//  bit_idx is 3 bits and is cleared on entry to DATA.
//   - DATA exits when bit_idx==7 and baud_cnt==CLKS_PER_BIT-1. No wrap past 7.
//  tx_en dropping mid-frame: the current frame completes, then the FSM returns to IDLE. A frame is never truncated.
//  data changing outside LOAD is ignored.
//  Only one ready pulse is issued per frame, so the memory address advances exactly once per frame.
//  Reset asserted mid-frame: tx=1 immediately (asynchronous) and the frame is abandoned.
//   - After release, the FSM restarts from IDLE; no partial ready pulse.
//  ready and done are never high in the same cycle.
//   - In streaming mode, done (last STOP cycle) is followed by ready (REQ) on the next cycle.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum tx_state_t {IDLE, REQ, LOAD, START, DATA, PARITY, STOP}
//   - localparam DEFAULT_CLKS_PER_BIT = 868
//  Sub-module uart_baud_gen (CLKS_PER_BIT):
//   - Inputs: clk, rst, clr. Output: tick, high when the count reaches CLKS_PER_BIT-1.
//   - Used for every bit timing.
//  FSM, shift register and parity logic live in uart_tx_core.
// TESTING (bench: CLKS_PER_BIT=4, memory model returns a new byte one cycle after ready)
//  T1 - Single 8N1 frame:
//   - Stimulus: reset, data=8'h12, tx_en pulsed high.
//   - Response: one ready pulse; tx = 0 | 0,1,0,0,1,0,0,0 | 1, each bit held 4 cycles.
//   - done pulses once, 40 cycles after START entry; busy then falls.
//  T2 - Streaming:
//   - Stimulus: tx_en held high, memory bytes 8'h12, 8'h34, 8'hC1.
//   - Response: ready pulses exactly 42 cycles apart.
//   - Decoded bytes arrive in order 12, 34, C1 with no idle between stop and the next start beyond REQ+LOAD.
//  T3 - Parity:
//   - Stimulus: PARITY_EN=1, bytes 8'h12 then 8'h34.
//   - Response: parity bit = 0 for 8'h12 and 1 for 8'h34; frame period 46 cycles.
//  T4 - tx_en drop mid-frame:
//   - Stimulus: deassert tx_en during DATA bit 3.
//   - Response: the frame finishes through stop; no further ready pulse; tx stays 1.
//  T5 - Async reset:
//   - Stimulus: assert rst between clock edges during DATA.
//   - Response: tx=1, busy=0, ready=0 before the next edge.
//   - After release with tx_en=1, a fresh REQ occurs and a full frame is sent.
//  T6 - Two stop bits:
//   - Stimulus: STOP_BITS=2, byte 8'hFE.
//   - Response: tx high for 8 cycles after data bit 7; done in the 8th of those cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; clr restarts the period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // pre_tick lets the FSM register a pulse that lands in the last cycle of a bit
    assign tick     = (r_cnt == LAST);
    assign pre_tick = (r_cnt == PRE);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: pulls one byte per frame from the byte memory and shifts it out as 8N1/8E1.
// All outputs are registered; a reset mid-frame abandons the frame and parks tx high.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_parity;
    logic       r_ready;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic w_clr;
    logic w_tick;
    logic w_pre_tick;
    logic w_last_stop;

    // Restart the bit period so START gets exactly CLKS_PER_BIT cycles
    assign w_clr       = (r_state == LOAD);
    assign w_last_stop = (r_bit_idx == 3'(STOP_BITS - 1));

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .tick    (w_tick),
        .pre_tick(w_pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_ready   <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (tx_en) begin
                        r_state <= REQ;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift  <= data;
                    r_parity <= ^data;
                    r_tx     <= 1'b0;
                    r_state  <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx      <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    // r_bit_idx doubles as the stop-bit counter here
                    if (w_pre_tick && w_last_stop) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_bit_idx <= '0;
                            if (tx_en) begin
                                r_state <= REQ;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign tx    = r_tx;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: three instances (8N1, 8E1, 8N2) at CLKS_PER_BIT=4.
`timescale 1ns/1ps
module tb_uart_tx_core;

    typedef struct {
        int         inst;
        logic [7:0] b;
        logic       p;
    } exp_t;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] tx_en;
    logic [7:0] data_a [3];
    logic [2:0] ready_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    logic [7:0] mem [3][32];
    int         maddr [3];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        q[$];
    int          cyc = 0;
    bit          in_frame [3];
    int          fcyc [3];
    int          frames_seen [3];
    int          ready_cnt [3];
    int          last_ready [3];
    bit          prev_done [3];
    bit          bad [3];
    logic [11:0] ef [3];
    logic [7:0]  rx [3];
    logic        rxpar [3];
    exp_t        cur [3];

    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tx_en(tx_en[0]), .data(data_a[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tx_en(tx_en[1]), .data(data_a[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst[2]), .tx_en(tx_en[2]), .data(data_a[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: registers the addressed byte on the ready edge, advances once per ready
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_v[i]) begin
                data_a[i] <= mem[i][maddr[i]];
                maddr[i]  <= maddr[i] + 1;
            end
        end
    end

    function automatic int flen(input int i);
        return (i == 0) ? 40 : 44;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push(input int inst, input logic [7:0] b, input logic p);
        exp_t e;
        e.inst = inst;
        e.b    = b;
        e.p    = p;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int i, input int target, input string nm);
        int k = 0;
        while (frames_seen[i] < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, frames_seen[i], target);
    endtask

    task automatic wait_ready(input int i, input int target, input string nm);
        int k = 0;
        while (ready_cnt[i] < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, ready_cnt[i], target);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    in_frame[i]  = 1'b0;
                    prev_done[i] = 1'b0;
                end else begin
                    if (prev_done[i]) chk("ready_after_done", ready_v[i], tx_en[i]);
                    if (ready_v[i]) begin
                        chk("ready_done_overlap", done_v[i], 0);
                        if (prev_done[i]) chk("frame_period", cyc - last_ready[i], flen(i) + 2);
                        ready_cnt[i]++;
                        last_ready[i] = cyc;
                    end
                    if (done_v[i]) chk("done_position", (in_frame[i] && fcyc[i] == flen(i) - 1), 1);
                    prev_done[i] = done_v[i];
                    if (!in_frame[i] && tx_v[i] == 1'b0) begin
                        n_tests++;
                        if (q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame: inst %0d started a frame, none expected", i);
                        end else begin
                            cur[i] = q.pop_front();
                            if (cur[i].inst != i) begin
                                n_fail++;
                                $display("FAIL frame_inst: got inst %0d expected inst %0d", i, cur[i].inst);
                            end
                            if (i == 1) ef[i] = {2'b11, cur[i].p, cur[i].b, 1'b0};
                            else        ef[i] = {3'b111, cur[i].b, 1'b0};
                            in_frame[i] = 1'b1;
                            fcyc[i]     = 0;
                            bad[i]      = 1'b0;
                            rx[i]       = 8'h00;
                            rxpar[i]    = 1'b0;
                        end
                    end
                    if (in_frame[i]) begin
                        if (tx_v[i] !== ef[i][fcyc[i] / 4] || busy_v[i] !== 1'b1) bad[i] = 1'b1;
                        if (fcyc[i] % 4 == 2) begin
                            if (fcyc[i] / 4 >= 1 && fcyc[i] / 4 <= 8) rx[i][fcyc[i] / 4 - 1] = tx_v[i];
                            if (i == 1 && fcyc[i] / 4 == 9) rxpar[i] = tx_v[i];
                        end
                        if (fcyc[i] == flen(i) - 1) begin
                            chk("byte", rx[i], cur[i].b);
                            if (i == 1) chk("parity", rxpar[i], cur[i].p);
                            chk("waveform", bad[i], 0);
                            frames_seen[i]++;
                            in_frame[i] = 1'b0;
                        end else begin
                            fcyc[i]++;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int base;
        int bf;
        int k;
        rst   = 3'b111;
        tx_en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            data_a[i]      = 8'h00;
            maddr[i]       = 0;
            in_frame[i]    = 1'b0;
            fcyc[i]        = 0;
            frames_seen[i] = 0;
            ready_cnt[i]   = 0;
            last_ready[i]  = 0;
            prev_done[i]   = 1'b0;
            for (int a = 0; a < 32; a++) mem[i][a] = 8'h00;
        end
        mem[0][0] = 8'h12; mem[0][1] = 8'h12; mem[0][2] = 8'h34; mem[0][3] = 8'hC1;
        mem[0][4] = 8'hA5; mem[0][5] = 8'h5A; mem[0][6] = 8'h3C;
        mem[1][0] = 8'h12; mem[1][1] = 8'h34;
        mem[2][0] = 8'hFE;

        fork
            monitor();
        join_none

        repeat (3) step();
        chk("rst_tx", tx_v, 3'b111);
        chk("rst_ready", ready_v, 3'b000);
        chk("rst_busy", busy_v, 3'b000);
        chk("rst_done", done_v, 3'b000);
        rst = 3'b000;
        repeat (2) step();

        // T1: single 8N1 frame, latency IDLE->REQ->LOAD->START
        push(0, 8'h12, 1'b0);
        tx_en[0] = 1'b1;
        step();
        chk("t1_req_ready", ready_v[0], 1);
        tx_en[0] = 1'b0;
        step();
        chk("t1_load_ready", ready_v[0], 0);
        chk("t1_load_tx", tx_v[0], 1);
        step();
        chk("t1_start_tx", tx_v[0], 0);
        wait_frames(0, 1, "t1_frames");
        repeat (2) step();
        chk("t1_busy_low", busy_v[0], 0);
        chk("t1_ready_count", ready_cnt[0], 1);

        // T2: streaming three bytes
        push(0, 8'h12, 1'b0);
        push(0, 8'h34, 1'b0);
        push(0, 8'hC1, 1'b0);
        base = ready_cnt[0];
        step();
        tx_en[0] = 1'b1;
        wait_ready(0, base + 3, "t2_ready_count");
        #1;
        tx_en[0] = 1'b0;
        wait_frames(0, 4, "t2_frames");
        repeat (10) step();
        chk("t2_no_extra_ready", ready_cnt[0], base + 3);

        // T3: even parity
        push(1, 8'h12, 1'b0);
        push(1, 8'h34, 1'b1);
        step();
        tx_en[1] = 1'b1;
        wait_ready(1, 2, "t3_ready_count");
        #1;
        tx_en[1] = 1'b0;
        wait_frames(1, 2, "t3_frames");

        // T4: tx_en dropped during data bit 3
        push(0, 8'hA5, 1'b0);
        base = ready_cnt[0];
        step();
        tx_en[0] = 1'b1;
        k = 0;
        while (!(in_frame[0] && fcyc[0] >= 17) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t4_reach_bit3", (in_frame[0] && fcyc[0] >= 17), 1);
        #1;
        tx_en[0] = 1'b0;
        wait_frames(0, 5, "t4_frames");
        repeat (20) step();
        chk("t4_no_more_ready", ready_cnt[0], base + 1);
        chk("t4_tx_idle", tx_v[0], 1);
        chk("t4_busy_idle", busy_v[0], 0);

        // T5: asynchronous reset during DATA, then a fresh frame
        push(0, 8'h5A, 1'b0);
        push(0, 8'h3C, 1'b0);
        bf = frames_seen[0];
        step();
        tx_en[0] = 1'b1;
        k = 0;
        while (!(in_frame[0] && fcyc[0] >= 10) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_data", (in_frame[0] && fcyc[0] >= 10), 1);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("t5_async_tx", tx_v[0], 1);
        chk("t5_async_busy", busy_v[0], 0);
        chk("t5_async_ready", ready_v[0], 0);
        @(negedge clk);
        #2;
        base = ready_cnt[0];
        rst[0] = 1'b0;
        wait_ready(0, base + 1, "t5_fresh_req");
        #1;
        tx_en[0] = 1'b0;
        wait_frames(0, bf + 1, "t5_frames");

        // T6: two stop bits
        push(2, 8'hFE, 1'b0);
        step();
        tx_en[2] = 1'b1;
        step();
        tx_en[2] = 1'b0;
        wait_frames(2, 1, "t6_frames");
        repeat (4) step();
        chk("t6_ready_count", ready_cnt[2], 1);
        chk("t6_busy_low", busy_v[2], 0);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
